// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: request/ready handshake with byte enables.
interface mem_access_stage_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memReady;

  modport master (
    output memReq, memWe, memAddr, memByteEn, memWdata,
    input  memRdata, memReady
  );

  modport slave (
    input  memReq, memWe, memAddr, memByteEn, memWdata,
    output memRdata, memReady
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: decodes load/store size, runs the data-memory handshake,
// aligns/extends load data and stalls upstream while an access is outstanding.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      regWriteFlagInput,
  input  logic                      memReadFlagInput,
  input  logic                      memWriteFlagInput,
  input  logic                      MemToRegInput,
  input  logic [31:0]               IRInput,
  input  logic [31:0]               ResultInput,
  input  logic [31:0]               BInput,
  input  logic [4:0]                regDestAddressInput,
  mem_access_stage_if.master        mem,
  output logic                      stallOut,
  output logic                      regWriteFlagOutput,
  output logic                      MemToRegOutput,
  output logic [31:0]               IROutput,
  output logic [31:0]               ResultOutput,
  output logic [4:0]                regDestAddressOutput,
  output logic                      alignError,
  output logic                      busError
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          abort_q, abort_d;

  logic [5:0]  opcode;
  size_t       size;
  logic        is_unsigned;
  logic        access;
  logic        is_load;
  logic        is_store;
  logic [1:0]  addr_lo;
  logic        misaligned;
  logic [3:0]  store_byte_en;
  logic [31:0] store_wdata;
  logic [31:0] rdata_shifted;
  logic [31:0] load_aligned;

  assign opcode               = IRInput[31:26];
  assign addr_lo              = ResultInput[1:0];
  assign access               = memReadFlagInput | memWriteFlagInput;
  assign is_load              = memReadFlagInput;
  assign is_store             = memWriteFlagInput & ~memReadFlagInput;
  assign IROutput             = IRInput;
  assign regDestAddressOutput = regDestAddressInput;
  assign MemToRegOutput       = MemToRegInput;

  // Unknown opcodes carrying a memory flag fall back to word size.
  always_comb begin
    size        = SZ_WORD;
    is_unsigned = 1'b0;
    case (opcode)
      6'h20, 6'h28: size = SZ_BYTE;
      6'h24: begin
        size        = SZ_BYTE;
        is_unsigned = 1'b1;
      end
      6'h21, 6'h29: size = SZ_HALF;
      6'h25: begin
        size        = SZ_HALF;
        is_unsigned = 1'b1;
      end
      default: size = SZ_WORD;
    endcase
  end

  assign misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                      ((size == SZ_WORD) && (addr_lo != 2'b00));

  always_comb begin
    store_byte_en = 4'b1111;
    store_wdata   = BInput;
    case (size)
      SZ_BYTE: begin
        store_byte_en = 4'b0001 << addr_lo;
        store_wdata   = {4{BInput[7:0]}};
      end
      SZ_HALF: begin
        store_byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_wdata   = {2{BInput[15:0]}};
      end
      default: begin
        store_byte_en = 4'b1111;
        store_wdata   = BInput;
      end
    endcase
  end

  // Shifting the word right by the byte offset puts the addressed lane at bit 0.
  assign rdata_shifted = mem.memRdata >> {addr_lo, 3'b000};

  always_comb begin
    load_aligned = mem.memRdata;
    case (size)
      SZ_BYTE: load_aligned = is_unsigned ? {24'h0, rdata_shifted[7:0]}
                                          : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      SZ_HALF: load_aligned = is_unsigned ? {16'h0, rdata_shifted[15:0]}
                                          : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_aligned = mem.memRdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      load_data_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      load_data_q <= load_data_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    wait_cnt_d         = wait_cnt_q;
    load_data_d        = load_data_q;
    abort_d            = abort_q;
    stallOut           = 1'b0;
    mem.memReq         = 1'b0;
    mem.memWe          = 1'b0;
    mem.memAddr        = '0;
    mem.memByteEn      = '0;
    mem.memWdata       = '0;
    alignError         = 1'b0;
    busError           = 1'b0;
    regWriteFlagOutput = regWriteFlagInput;
    ResultOutput       = ResultInput;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        abort_d    = 1'b0;
        if (access) begin
          if (misaligned) begin
            alignError         = 1'b1;
            regWriteFlagOutput = 1'b0;
          end else begin
            stallOut = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stallOut      = 1'b1;
        mem.memReq    = 1'b1;
        mem.memWe     = is_store;
        mem.memAddr   = {ResultInput[31:2], 2'b00};
        mem.memByteEn = is_store ? store_byte_en : 4'b1111;
        mem.memWdata  = store_wdata;
        if (mem.memReady) begin
          load_data_d = load_aligned;
          abort_d     = 1'b0;
          state_d     = DONE;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          abort_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (is_load) begin
          ResultOutput = load_data_q;
        end
        if (abort_q) begin
          busError           = 1'b1;
          regWriteFlagOutput = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (built with TIMEOUT=4).
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        regWriteFlagInput;
  logic        memReadFlagInput;
  logic        memWriteFlagInput;
  logic        MemToRegInput;
  logic [31:0] IRInput;
  logic [31:0] ResultInput;
  logic [31:0] BInput;
  logic [4:0]  regDestAddressInput;
  logic        stallOut;
  logic        regWriteFlagOutput;
  logic        MemToRegOutput;
  logic [31:0] IROutput;
  logic [31:0] ResultOutput;
  logic [4:0]  regDestAddressOutput;
  logic        alignError;
  logic        busError;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_access_stage_if mem_bus ();

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .regWriteFlagInput    (regWriteFlagInput),
    .memReadFlagInput     (memReadFlagInput),
    .memWriteFlagInput    (memWriteFlagInput),
    .MemToRegInput        (MemToRegInput),
    .IRInput              (IRInput),
    .ResultInput          (ResultInput),
    .BInput               (BInput),
    .regDestAddressInput  (regDestAddressInput),
    .mem                  (mem_bus),
    .stallOut             (stallOut),
    .regWriteFlagOutput   (regWriteFlagOutput),
    .MemToRegOutput       (MemToRegOutput),
    .IROutput             (IROutput),
    .ResultOutput         (ResultOutput),
    .regDestAddressOutput (regDestAddressOutput),
    .alignError           (alignError),
    .busError             (busError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic rw, input logic mr,
                           input logic mw, input logic [31:0] res, input logic [31:0] b);
    IRInput             = {op, 5'd1, 5'd2, 16'h0};
    regWriteFlagInput   = rw;
    memReadFlagInput    = mr;
    memWriteFlagInput   = mw;
    MemToRegInput       = mr;
    ResultInput         = res;
    BInput              = b;
    regDestAddressInput = 5'd9;
  endtask

  task automatic set_nop;
    set_instr(6'h00, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mem_bus.memReady = 1'b0;
    mem_bus.memRdata = 32'h0;
    set_nop();
    #2;
    tests_run++;
    if (mem_bus.memReq !== 1'b0 || stallOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req_stall: got req=%b stall=%b expected 0 0", mem_bus.memReq, stallOut);
    end
    tests_run++;
    if (mem_bus.memByteEn !== 4'h0 || mem_bus.memAddr !== 32'h0 || mem_bus.memWdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got be=%h addr=%h wdata=%h expected 0 0 0",
               mem_bus.memByteEn, mem_bus.memAddr, mem_bus.memWdata);
    end
    tests_run++;
    if (alignError !== 1'b0 || busError !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_errors: got align=%b bus=%b expected 0 0", alignError, busError);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lw;
    set_instr(6'h23, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    tests_run++;
    if (stallOut !== 1'b1 || mem_bus.memReq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_cycle0: got stall=%b req=%b expected 1 0", stallOut, mem_bus.memReq);
    end
    tick();
    mem_bus.memReady = 1'b1;
    mem_bus.memRdata = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++;
    if (stallOut !== 1'b1 || mem_bus.memReq !== 1'b1 || mem_bus.memWe !== 1'b0 ||
        mem_bus.memAddr !== 32'h100 || mem_bus.memByteEn !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL lw_cycle1: got stall=%b req=%b we=%b addr=%h be=%h expected 1 1 0 00000100 f",
               stallOut, mem_bus.memReq, mem_bus.memWe, mem_bus.memAddr, mem_bus.memByteEn);
    end
    tick();
    mem_bus.memReady = 1'b0;
    mem_bus.memRdata = 32'h0;
    @(negedge clk);
    tests_run++;
    if (stallOut !== 1'b0 || ResultOutput !== 32'hDEADBEEF || regWriteFlagOutput !== 1'b1 ||
        mem_bus.memReq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL lw_done: got stall=%b result=%h rw=%b req=%b expected 0 deadbeef 1 0",
               stallOut, ResultOutput, regWriteFlagOutput, mem_bus.memReq);
    end
    tick();
    set_nop();
  endtask

  task automatic test_lb_lbu;
    logic [5:0]  ops  [3] = '{6'h20, 6'h24, 6'h21};
    logic [31:0] addrs[3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    for (int i = 0; i < 3; i++) begin
      set_instr(ops[i], 1'b1, 1'b1, 1'b0, addrs[i], 32'h0);
      tick();
      mem_bus.memReady = 1'b1;
      mem_bus.memRdata = 32'h80FFFFFF;
      tick();
      mem_bus.memReady = 1'b0;
      mem_bus.memRdata = 32'h0;
      @(negedge clk);
      tests_run++;
      if (ResultOutput !== exps[i]) begin
        tests_failed++;
        $display("[TB] FAIL load_extend_%0d: got %h expected %h", i, ResultOutput, exps[i]);
      end
      tick();
      set_nop();
    end
  endtask

  task automatic test_sh_wait;
    int stall_cycles = 0;
    set_instr(6'h29, 1'b0, 1'b0, 1'b1, 32'h206, 32'h1234ABCD);
    @(negedge clk);
    if (stallOut === 1'b1) stall_cycles++;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) mem_bus.memReady = 1'b1;
      @(negedge clk);
      if (stallOut === 1'b1) stall_cycles++;
      tests_run++;
      if (mem_bus.memReq !== 1'b1 || mem_bus.memWe !== 1'b1 || mem_bus.memByteEn !== 4'b1100 ||
          mem_bus.memWdata !== 32'hABCDABCD || mem_bus.memAddr !== 32'h204) begin
        tests_failed++;
        $display("[TB] FAIL sh_req_c%0d: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 1100 abcdabcd 00000204",
                 c, mem_bus.memReq, mem_bus.memWe, mem_bus.memByteEn, mem_bus.memWdata, mem_bus.memAddr);
      end
    end
    tick();
    mem_bus.memReady = 1'b0;
    @(negedge clk);
    if (stallOut === 1'b1) stall_cycles++;
    tests_run++;
    if (stall_cycles != 4 || mem_bus.memReq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sh_stall_count: got stalls=%0d req=%b expected 4 0", stall_cycles, mem_bus.memReq);
    end
    tick();
    set_nop();
  endtask

  task automatic test_misaligned;
    set_instr(6'h23, 1'b1, 1'b1, 1'b0, 32'h101, 32'h0);
    @(negedge clk);
    tests_run++;
    if (mem_bus.memReq !== 1'b0 || alignError !== 1'b1 || regWriteFlagOutput !== 1'b0 ||
        stallOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL misaligned_lw: got req=%b align=%b rw=%b stall=%b expected 0 1 0 0",
               mem_bus.memReq, alignError, regWriteFlagOutput, stallOut);
    end
    tick();
    set_nop();
    @(negedge clk);
    tests_run++;
    if (alignError !== 1'b0 || mem_bus.memReq !== 1'b0 || stallOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL misaligned_after: got align=%b req=%b stall=%b expected 0 0 0",
               alignError, mem_bus.memReq, stallOut);
    end
    tick();
  endtask

  task automatic test_timeout;
    int  req_cycles = 0;
    logic early_bus = 1'b0;
    set_instr(6'h23, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_bus.memReq !== 1'b1) break;
      req_cycles++;
      if (busError === 1'b1) early_bus = 1'b1;
      tick();
    end
    tests_run++;
    if (req_cycles != 4 || early_bus !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_req_len: got req_cycles=%0d early_bus=%b expected 4 0", req_cycles, early_bus);
    end
    tests_run++;
    if (busError !== 1'b1 || regWriteFlagOutput !== 1'b0 || stallOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_done: got bus=%b rw=%b stall=%b expected 1 0 0",
               busError, regWriteFlagOutput, stallOut);
    end
    tick();
    set_instr(6'h00, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
    @(negedge clk);
    tests_run++;
    if (busError !== 1'b0 || ResultOutput !== 32'h77 || regWriteFlagOutput !== 1'b1 || stallOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_next: got bus=%b result=%h rw=%b stall=%b expected 0 00000077 1 0",
               busError, ResultOutput, regWriteFlagOutput, stallOut);
    end
    tick();
    set_nop();
  endtask

  task automatic test_reset_mid_req;
    set_instr(6'h2B, 1'b0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D);
    tick();
    tick();
    tests_run++;
    if (mem_bus.memReq !== 1'b1 || mem_bus.memWe !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_req_before: got req=%b we=%b expected 1 1", mem_bus.memReq, mem_bus.memWe);
    end
    #1;
    reset = 1'b1;
    set_instr(6'h00, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
    #1;
    tests_run++;
    if (mem_bus.memReq !== 1'b0 || stallOut !== 1'b0 || mem_bus.memWe !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_req_drop: got req=%b stall=%b we=%b expected 0 0 0",
               mem_bus.memReq, stallOut, mem_bus.memWe);
    end
    #4;
    reset = 1'b0;
    tick();
    @(negedge clk);
    tests_run++;
    if (ResultOutput !== 32'h55 || stallOut !== 1'b0 || mem_bus.memReq !== 1'b0 ||
        regWriteFlagOutput !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_then_add: got result=%h stall=%b req=%b rw=%b expected 00000055 0 0 1",
               ResultOutput, stallOut, mem_bus.memReq, regWriteFlagOutput);
    end
    tick();
    set_nop();
    @(negedge clk);
    tests_run++;
    if (mem_bus.memReq !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_no_write: got req=%b expected 0", mem_bus.memReq);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    set_instr(6'h23, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    tick();
    mem_bus.memReady = 1'b1;
    mem_bus.memRdata = 32'h11223344;
    tick();
    mem_bus.memReady = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ResultOutput !== 32'h11223344 || stallOut !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_lw_done: got result=%h stall=%b expected 11223344 0", ResultOutput, stallOut);
    end
    tick();
    set_instr(6'h28, 1'b0, 1'b0, 1'b1, 32'h101, 32'h000000A5);
    @(negedge clk);
    tests_run++;
    if (stallOut !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_sb_accept: got stall=%b expected 1", stallOut);
    end
    tick();
    mem_bus.memReady = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_bus.memReq !== 1'b1 || mem_bus.memWe !== 1'b1 || mem_bus.memByteEn !== 4'b0010 ||
        mem_bus.memWdata !== 32'hA5A5A5A5 || mem_bus.memAddr !== 32'h100) begin
      tests_failed++;
      $display("[TB] FAIL b2b_sb_req: got req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 0010 a5a5a5a5 00000100",
               mem_bus.memReq, mem_bus.memWe, mem_bus.memByteEn, mem_bus.memWdata, mem_bus.memAddr);
    end
    tick();
    mem_bus.memReady = 1'b0;
    @(negedge clk);
    tests_run++;
    if (stallOut !== 1'b0 || mem_bus.memReq !== 1'b0 || busError !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_sb_done: got stall=%b req=%b bus=%b expected 0 0 0",
               stallOut, mem_bus.memReq, busError);
    end
    tick();
    set_nop();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM/WB register. It decodes load and store size from the instruction word and drives a ready-handshaked data-memory port with byte enables. It aligns and extends load data, and stalls the upstream pipeline while an access is outstanding. It presents the final result, destination and control flags that MEM/WB captures.

## Interface
- `TIMEOUT`, default 16: maximum cycles in REQ waiting for `memReady` before the access aborts (≥2).
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `regWriteFlagInput`, `memReadFlagInput`, `memWriteFlagInput`, `MemToRegInput`  in  1 each: control bits from EX/MEM.
- `IRInput`  in  32: instruction word; opcode is `IR[31:26]`.
- `ResultInput`  in  32: ALU result, which is also the effective address for loads and stores.
- `BInput`  in  32: store data.
- `regDestAddressInput`  in  5: destination register.
- `memRdata`  in  32: read data from data memory.
- `memReady`  in  1: memory has completed the access this cycle.
- `memReq`, `memWe`  out  1: request strobe and write enable.
- `memAddr`  out  32: word address, `{ResultInput[31:2],2'b00}`.
- `memByteEn`  out  4: byte lanes, little-endian (lane 0 = `data[7:0]`).
- `memWdata`  out  32: lane-replicated store data.
- `stallOut`  out  1: hold PC, IF/ID, ID/EX and EX/MEM.
- `regWriteFlagOutput`, `MemToRegOutput`  out  1: control bits to MEM/WB.
- `IROutput`  out  32: instruction word to MEM/WB.
- `ResultOutput`  out  32: result to MEM/WB.
- `regDestAddressOutput`  out  5: destination register to MEM/WB.
- `alignError`, `busError`  out  1: one-cycle error pulses.

## Operation
- Decode from `IR[31:26]`:
  - loads: `0x20` lb, `0x21` lh, `0x23` lw, `0x24` lbu, `0x25` lhu.
  - stores: `0x28` sb, `0x29` sh, `0x2B` sw.
  - Any other opcode with a memory flag set is treated as word size.
- Access = `memReadFlagInput | memWriteFlagInput`. If both flags are set, the access is a load and the store is ignored.
- Misalignment:
  - halfword with `addr[0]=1`, or word with `addr[1:0]≠0`.
  - Checked in IDLE. No request is issued and no stall occurs.
  - `alignError` pulses for that cycle and `regWriteFlagOutput` is forced 0.
- FSM states IDLE, REQ, DONE:
  - IDLE: an aligned access raises `stallOut`; next state is REQ. A non-access instruction passes through with `stallOut=0`.
  - REQ: `memReq=1`, `stallOut=1`, and `memWe` is set for stores. Address, enables and wdata are driven from the held EX/MEM inputs.
    - `memReady=1`: capture the aligned load data into `loadData` and go to DONE.
    - Wait counter reaches `TIMEOUT-1` without ready: go to DONE with `abort=1`.
  - DONE: `stallOut=0`, `memReq=0`, and MEM/WB captures at the end of the cycle. Next state is IDLE.
    - If `abort`: `busError` pulses and `regWriteFlagOutput` is forced 0.
- Store enables and data:
  - sb: `memByteEn = 1<<addr[1:0]`, wdata `{4{B[7:0]}}`.
  - sh: `memByteEn = addr[1] ? 4'b1100 : 4'b0011`, wdata `{2{B[15:0]}}`.
  - sw: `memByteEn = 4'b1111`, wdata `B`.
- Loads use `memByteEn = 4'b1111`. The lane is selected by `addr[1:0]`, then sign-extended (lb, lh) or zero-extended (lbu, lhu).
- `ResultOutput` is `loadData` for a load in DONE, otherwise `ResultInput`.
- `IROutput`, `regDestAddressOutput` and `MemToRegOutput` pass through combinationally.
- EX/MEM contents are stable while `stallOut=1`, because upstream guarantees the freeze.

## Timing
- Reset (async, immediate) sets:
  - state IDLE, wait counter 0, `loadData` 0, `abort` 0.
  - `memReq`, `memWe`, `memByteEn`, `memAddr` and `memWdata` 0 outside REQ.
  - `stallOut`, `alignError` and `busError` 0.
- Reset during REQ drops `memReq` in the same cycle, and no write completes afterward.
- Access presented in cycle 0, `memReady` in cycle k (k≥1):
  - REQ spans cycles 1..k.
  - DONE is cycle k+1, and MEM/WB loads at the end of k+1.
  - `stallOut` is high in cycles 0..k.
- Zero-wait memory (ready in cycle 1) gives 2 stall cycles.
- Timeout: REQ lasts exactly `TIMEOUT` cycles, DONE follows, and `busError` is high in DONE only.
- `memReady` outside REQ is ignored.
- An instruction following the access is accepted in cycle k+2 and may immediately start a new access.

## Test plan
- **lw, 1-cycle ready:** addr `0x100`, rdata `0xDEADBEEF`, ready in cycle 1.
  - `stallOut` high cycles 0–1.
  - Cycle 2: `ResultOutput=0xDEADBEEF`, `regWriteFlagOutput=1`.
- **lb vs lbu:** addr `0x103`, rdata `0x80FFFFFF`.
  - lb gives `0xFFFFFF80`; lbu gives `0x00000080`.
  - lh at `0x102` gives `0xFFFF80FF`.
- **sh with wait states:** addr `0x206`, B `0x1234ABCD`, ready after 3 REQ cycles.
  - `memByteEn=1100`, `memWdata=0xABCDABCD`, `memWe=1`.
  - `stallOut` high for 4 cycles.
- **Misaligned lw:** addr `0x101`.
  - No `memReq`, `alignError` 1-cycle pulse, `regWriteFlagOutput=0`, no stall.
- **Timeout:** `TIMEOUT=4`, `memReady` held low.
  - `memReq` high exactly 4 cycles, then `busError` pulse with `regWriteFlagOutput=0`.
  - Next instruction flows normally.
- **Reset mid-REQ, then ALU op:** assert `reset` in cycle 2 of REQ.
  - `memReq` and `stallOut` drop at once and the state returns to IDLE.
  - A following add with result `0x55` passes to `ResultOutput=0x55` with no stall.
